addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, elastic, pipelined add/subtract unit with valid/ready handshakes on both sides.
- Operands are split into stages_p equal chunks. Each pipeline stage resolves one chunk and forwards its carry to the next stage, so wide operands meet timing at full throughput.
- Supports add or subtract with carry/borrow-in, and reports carry/borrow-out and signed overflow.
- Sits between the UART command decoder and the response formatter of the ALU datapath.

Parameters:
- width_p, default 32: operand and result width in bits.
- stages_p, default 2: number of pipeline stages (chunks). width_p must be divisible by stages_p, and stages_p must be at least 1. Chunk width cw = width_p/stages_p.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream has a transaction.
- ready_o  output  1  unit can accept a transaction this cycle.
- operand_a_i  input  width_p  operand A.
- operand_b_i  input  width_p  operand B.
- sub_i  input  1  0 = add, 1 = subtract.
- carry_i  input  1  carry-in (add) or borrow-in (sub).
- ready_i  input  1  downstream accepts the result.
- valid_o  output  1  result is valid.
- sum_o  output  width_p  result.
- carry_o  output  1  carry-out (add) or borrow-out (sub).
- overflow_o  output  1  signed two's-complement overflow.

Behaviour:
- Arithmetic:
  - add: {carry_o, sum_o} = a + b + carry_i.
  - sub: computed as a + ~b + ~carry_i (width_p+1 bits). sum_o = a - b - carry_i mod 2^width_p. carry_o = inverted chain carry-out, so carry_o = 1 iff a < b + carry_i (unsigned).
  - overflow_o = (a_msb == b_eff_msb) & (sum_msb != a_msb), where b_eff = sub_i ? ~b : b.
- Pipeline structure:
  - Stage k (0..stages_p-1) holds valid_k, the registered carry, the completed low sum chunks [k*cw+cw-1:0], and the still-unused upper chunks of a and b_eff.
  - Stage 0 computes chunk 0 from the inputs. Stage k computes chunk k from stage k-1 registers.
  - Output registers are the last stage.
- Handshake:
  - Transfer in occurs when valid_i & ready_o. Transfer out occurs when valid_o & ready_i.
  - Per-stage ready: rdy_k = ~valid_k | rdy_{k+1}, with rdy_{stages_p} = ready_i; ready_o = rdy_0. The ready path is combinational from ready_i; no combinational path exists from valid_i to valid_o.
  - A stage loads when its rdy is high: valid_k <= valid_{k-1} (valid_i for k=0). Data registers load only when the incoming valid is high and rdy_k is high; otherwise they hold.
  - When a stage's rdy is low, that stage and all upstream stages hold. No data is lost or duplicated, and order is preserved.
- Latency and throughput:
  - A transaction accepted at edge N produces valid_o high after edge N+stages_p-1, i.e. the result is visible stages_p cycles after the accept cycle with no stall. stages_p=1 gives 1-cycle registered behaviour.
  - Throughput is 1 transaction/cycle while ready_i=1. Capacity is stages_p transactions.
- Reset (synchronous, active-high):
  - All valid bits cleared; sum_o=0, carry_o=0, overflow_o=0, valid_o=0 from the cycle after the reset edge.
  - Asserting reset mid-operation discards all in-flight transactions; no partial result is emitted.
  - ready_o=1 during and after reset (follows ~valid_0 | ...).
- Boundaries:
  - Full pipeline with ready_i=0 → ready_o=0; outputs are stable and held.
  - Simultaneous accept and drain on a full pipeline: ready_o=1 while ready_i=1, and a new item enters as the oldest leaves.
  - Outputs hold their last value when valid_o=0 after draining.

Test Plan (width_p=32, stages_p=2 unless noted):
- Add wrap: a=0xFFFF_FFFF, b=0x1, sub=0, cin=0 → sum=0x0000_0000, carry=1, ovf=0; valid_o high 2 cycles after accept.
- Cross-chunk carry: a=0x0000_FFFF, b=0x1 → sum=0x0001_0000, carry=0. Also a=0x7FFF_FFFF, b=1 → sum=0x8000_0000, ovf=1.
- Subtract: 5-7 cin=0 → sum=0xFFFF_FFFE, carry(borrow)=1, ovf=0. 0x8000_0000-1 → sum=0x7FFF_FFFF, borrow=0, ovf=1. 10-3 cin=1 → sum=6, borrow=0.
- Backpressure: drive 6 back-to-back transactions; hold ready_i=0 for cycles 3-7 → ready_o=0 once 2 items are held. All 6 results emerge in order, each exactly once, with stable outputs while stalled.
- Reset mid-flight: two items in the pipeline, assert reset 1 cycle → valid_o=0, sum_o=0, carry_o=0, overflow_o=0 next cycle; no stale result appears afterward.
- width_p=8, stages_p=1: a=0x7F, b=0x01 → sum=0x80, ovf=1, carry=0; valid_o 1 cycle after accept; continuous streaming at 1/cycle.

Source files
------------

// File: rtl/addsub_pipe_if.sv
// Handshake bundle for the pipelined add/subtract unit.
// The slave side is the arithmetic unit; the master side feeds operands and drains results.
interface addsub_pipe_if #(
    parameter int width_p = 32
);
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] operand_a_i;
    logic [width_p-1:0] operand_b_i;
    logic               sub_i;
    logic               carry_i;
    logic               ready_i;
    logic               valid_o;
    logic [width_p-1:0] sum_o;
    logic               carry_o;
    logic               overflow_o;

    modport master (
        output valid_i, operand_a_i, operand_b_i, sub_i, carry_i, ready_i,
        input  ready_o, valid_o, sum_o, carry_o, overflow_o
    );

    modport slave (
        input  valid_i, operand_a_i, operand_b_i, sub_i, carry_i, ready_i,
        output ready_o, valid_o, sum_o, carry_o, overflow_o
    );
endinterface

// File: rtl/addsub_pipe.sv
// Elastic pipelined add/subtract unit.
// Operands are cut into stages_p chunks of cw bits; stage k adds chunk k and hands its
// carry to stage k+1. Each stage keeps only the operand bits not yet consumed and the
// sum bits already produced, so register widths shrink/grow along the pipe.
// width_p must be a multiple of stages_p and stages_p must be at least 1.
module addsub_pipe #(
    parameter int width_p  = 32,
    parameter int stages_p = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    addsub_pipe_if.slave bus
);
    localparam int cw   = width_p / stages_p;
    localparam int last = stages_p - 1;

    logic [stages_p-1:0] valid_w;
    logic [stages_p-1:0] rdy;

    // Ready ripples backwards from the downstream sink: a stage may load if it is empty
    // or if the stage after it is able to move on this cycle.
    always_comb begin : ready_chain
        logic r;
        r   = bus.ready_i;
        rdy = '0;
        for (int k = stages_p - 1; k >= 0; k--) begin
            r      = ~valid_w[k] | r;
            rdy[k] = r;
        end
    end

    genvar gi;
    for (gi = 0; gi < stages_p; gi++) begin : g_stage
        localparam int rem_w  = width_p - gi * cw;  // unconsumed operand bits, this chunk included
        localparam int done_w = (gi + 1) * cw;      // sum bits known after this stage

        logic              in_valid;
        logic              in_carry;
        logic              in_sub;
        logic [rem_w-1:0]  in_a;
        logic [rem_w-1:0]  in_b;
        logic [done_w-1:0] sum_new;
        logic [cw:0]       chunk;
        logic              load;

        logic              valid_q, valid_d;
        logic [done_w-1:0] sum_q, sum_d;

        if (gi == 0) begin : g_in
            // Subtraction becomes a + ~b + ~borrow, so B and the carry-in are conditioned here.
            assign in_valid = bus.valid_i;
            assign in_sub   = bus.sub_i;
            assign in_carry = bus.carry_i ^ bus.sub_i;
            assign in_a     = bus.operand_a_i;
            assign in_b     = bus.sub_i ? ~bus.operand_b_i : bus.operand_b_i;
            assign sum_new  = chunk[cw-1:0];
        end else begin : g_in
            assign in_valid = g_stage[gi-1].valid_q;
            assign in_sub   = g_stage[gi-1].g_fwd.sub_q;
            assign in_carry = g_stage[gi-1].g_fwd.carry_q;
            assign in_a     = g_stage[gi-1].g_fwd.a_q;
            assign in_b     = g_stage[gi-1].g_fwd.b_q;
            assign sum_new  = {chunk[cw-1:0], g_stage[gi-1].sum_q};
        end

        assign chunk = {1'b0, in_a[cw-1:0]} + {1'b0, in_b[cw-1:0]} + (cw+1)'(in_carry);
        assign load  = rdy[gi] & in_valid;

        // Valid follows upstream whenever this stage can move; sum bits only on a real load.
        always_comb begin
            valid_d = rdy[gi] ? in_valid : valid_q;
            sum_d   = load ? sum_new : sum_q;
        end

        // Stage state register.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
            end else begin
                valid_q <= valid_d;
                sum_q   <= sum_d;
            end
        end

        assign valid_w[gi] = valid_q;

        if (gi < last) begin : g_fwd
            localparam int fwd_w = rem_w - cw;

            logic             carry_q, carry_d;
            logic             sub_q, sub_d;
            logic [fwd_w-1:0] a_q, a_d;
            logic [fwd_w-1:0] b_q, b_d;

            // Chain carry, mode and the untouched upper operand chunks travel with the item.
            always_comb begin
                carry_d = carry_q;
                sub_d   = sub_q;
                a_d     = a_q;
                b_d     = b_q;
                if (load) begin
                    carry_d = chunk[cw];
                    sub_d   = in_sub;
                    a_d     = in_a[rem_w-1:cw];
                    b_d     = in_b[rem_w-1:cw];
                end
            end

            // Forwarded operand register.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    carry_q <= 1'b0;
                    sub_q   <= 1'b0;
                    a_q     <= '0;
                    b_q     <= '0;
                end else begin
                    carry_q <= carry_d;
                    sub_q   <= sub_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                end
            end
        end else begin : g_last
            logic carry_q, carry_d;
            logic ovf_q, ovf_d;

            // Final chunk: borrow is the inverted chain carry; overflow looks at the sign bits
            // of A, effective B and the result.
            always_comb begin
                carry_d = carry_q;
                ovf_d   = ovf_q;
                if (load) begin
                    carry_d = chunk[cw] ^ in_sub;
                    ovf_d   = (in_a[rem_w-1] == in_b[rem_w-1]) & (chunk[cw-1] != in_a[rem_w-1]);
                end
            end

            // Output flag register.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                end else begin
                    carry_q <= carry_d;
                    ovf_q   <= ovf_d;
                end
            end
        end
    end

    assign bus.ready_o    = rdy[0];
    assign bus.valid_o    = g_stage[last].valid_q;
    assign bus.sum_o      = g_stage[last].sum_q;
    assign bus.carry_o    = g_stage[last].g_last.carry_q;
    assign bus.overflow_o = g_stage[last].g_last.ovf_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: a 32-bit/2-stage instance and an 8-bit/1-stage instance.
// Expected results come from a reference model and are queued on accept, popped on output.
module tb_addsub_pipe;
    localparam int W  = 32;
    localparam int S  = 2;
    localparam int WN = 8;

    typedef struct packed {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    localparam vec_t VECS [7] = '{
        '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0},
        '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1},
        '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b0, 1'b0}
    };

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    addsub_pipe_if #(.width_p(W))  bus_a ();
    addsub_pipe_if #(.width_p(WN)) bus_b ();

    addsub_pipe #(.width_p(W), .stages_p(S)) dut_a (
        .clk_i   (clk),
        .reset_i (rst_a),
        .bus     (bus_a.slave)
    );

    addsub_pipe #(.width_p(WN), .stages_p(1)) dut_b (
        .clk_i   (clk),
        .reset_i (rst_b),
        .bus     (bus_b.slave)
    );

    int   checks = 0;
    int   passed = 0;
    res_t exp_a [$];
    res_t exp_b [$];

    // Reference: plain wide arithmetic, overflow from operand/result signs.
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin);
        logic [63:0] full;
        logic [63:0] mask;
        logic        am, bm, sm;
        res_t        r;
        mask = (64'd1 << w) - 64'd1;
        if (sub) full = {32'd0, a} - {32'd0, b} - {63'd0, cin};
        else     full = {32'd0, a} + {32'd0, b} + {63'd0, cin};
        r.sum   = 32'(full & mask);
        r.carry = full[w];
        am = a[w-1];
        bm = b[w-1];
        sm = full[w-1];
        r.ovf = sub ? ((am != bm) && (sm != am)) : ((am == bm) && (sm != am));
        return r;
    endfunction

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus_a.ready_o !== 1'b1) $display("FAIL reset_ready_a: got %b want 1", bus_a.ready_o);
        else passed++;
        checks++;
        if (bus_b.ready_o !== 1'b1) $display("FAIL reset_ready_b: got %b want 1", bus_b.ready_o);
        else passed++;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bus_a.valid_o, bus_a.sum_o, bus_a.carry_o, bus_a.overflow_o} !== 35'd0)
            $display("FAIL reset_outputs_a: valid=%b sum=%h c=%b v=%b want all 0",
                     bus_a.valid_o, bus_a.sum_o, bus_a.carry_o, bus_a.overflow_o);
        else passed++;
        checks++;
        if ({bus_b.valid_o, bus_b.sum_o, bus_b.carry_o, bus_b.overflow_o} !== 11'd0)
            $display("FAIL reset_outputs_b: valid=%b sum=%h c=%b v=%b want all 0",
                     bus_b.valid_o, bus_b.sum_o, bus_b.carry_o, bus_b.overflow_o);
        else passed++;
        checks++;
        if (bus_a.ready_o !== 1'b1) $display("FAIL post_reset_ready_a: got %b want 1", bus_a.ready_o);
        else passed++;
    endtask

    task automatic test_arith();
        int lat;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus_a.valid_i     = 1'b1;
            bus_a.operand_a_i = VECS[i].a;
            bus_a.operand_b_i = VECS[i].b;
            bus_a.sub_i       = VECS[i].sub;
            bus_a.carry_i     = VECS[i].cin;
            bus_a.ready_i     = 1'b1;
            #1;
            checks++;
            if (bus_a.ready_o !== 1'b1) $display("FAIL arith_ready[%0d]: got %b want 1", i, bus_a.ready_o);
            else passed++;
            @(posedge clk);
            @(negedge clk);
            bus_a.valid_i = 1'b0;
            #1;
            lat = 0;
            while (bus_a.valid_o !== 1'b1 && lat < 8) begin
                @(posedge clk);
                lat++;
                @(negedge clk); #1;
            end
            checks++;
            if (lat !== S - 1) $display("FAIL arith_latency[%0d]: got %0d extra edges want %0d", i, lat, S - 1);
            else passed++;
            checks++;
            if (bus_a.sum_o !== VECS[i].sum) $display("FAIL arith_sum[%0d]: got %h want %h", i, bus_a.sum_o, VECS[i].sum);
            else passed++;
            checks++;
            if (bus_a.carry_o !== VECS[i].carry) $display("FAIL arith_carry[%0d]: got %b want %b", i, bus_a.carry_o, VECS[i].carry);
            else passed++;
            checks++;
            if (bus_a.overflow_o !== VECS[i].ovf) $display("FAIL arith_ovf[%0d]: got %b want %b", i, bus_a.overflow_o, VECS[i].ovf);
            else passed++;
            $display("arith %0d: a=%h b=%h sub=%b cin=%b -> sum=%h c=%b v=%b lat=%0d",
                     i, VECS[i].a, VECS[i].b, VECS[i].sub, VECS[i].cin,
                     bus_a.sum_o, bus_a.carry_o, bus_a.overflow_o, lat);
        end
        // Result drains on the next edge; outputs must hold the last value afterwards.
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (bus_a.valid_o !== 1'b0) $display("FAIL drain_valid: got %b want 0", bus_a.valid_o);
        else passed++;
        checks++;
        if (bus_a.sum_o !== VECS[6].sum) $display("FAIL drain_hold: got %h want %h", bus_a.sum_o, VECS[6].sum);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic        vs [6];
        logic        vc [6];
        int          sent = 0;
        int          got  = 0;
        logic        held = 1'b0;
        res_t        hv;
        res_t        o;
        res_t        e;
        for (int i = 0; i < 6; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vs[i] = 1'($urandom_range(0, 1));
            vc[i] = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            bus_a.ready_i = (cyc < 3 || cyc > 7);
            bus_a.valid_i = (sent < 6);
            if (sent < 6) begin
                bus_a.operand_a_i = va[sent];
                bus_a.operand_b_i = vb[sent];
                bus_a.sub_i       = vs[sent];
                bus_a.carry_i     = vc[sent];
            end
            #1;
            o.sum   = bus_a.sum_o;
            o.carry = bus_a.carry_o;
            o.ovf   = bus_a.overflow_o;
            if (cyc == 3 || cyc == 7) begin
                checks++;
                if (bus_a.ready_o !== 1'b0) $display("FAIL bp_full_ready cyc%0d: got %b want 0", cyc, bus_a.ready_o);
                else passed++;
            end
            if (cyc == 8) begin
                checks++;
                if (bus_a.ready_o !== 1'b1) $display("FAIL bp_accept_drain: got %b want 1", bus_a.ready_o);
                else passed++;
            end
            if (bus_a.valid_o === 1'b1) begin
                if (held) begin
                    checks++;
                    if (o !== hv) $display("FAIL bp_stable cyc%0d: got %h want %h", cyc, o, hv);
                    else passed++;
                end
                if (bus_a.ready_i) begin
                    checks++;
                    if (exp_a.size() == 0) begin
                        $display("FAIL bp_unexpected cyc%0d: got %h want nothing", cyc, o);
                    end else begin
                        e = exp_a.pop_front();
                        if (o !== e) $display("FAIL bp_result[%0d]: got %h want %h", got, o, e);
                        else passed++;
                        $display("bp out %0d: sum=%h c=%b v=%b", got, o.sum, o.carry, o.ovf);
                    end
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hv   = o;
                end
            end
            if (bus_a.valid_i && bus_a.ready_o) begin
                exp_a.push_back(model(W, va[sent], vb[sent], vs[sent], vc[sent]));
                sent++;
            end
        end
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        bus_a.ready_i = 1'b1;
        checks++;
        if (got !== 6) $display("FAIL bp_count: got %0d results want 6", got);
        else passed++;
        checks++;
        if (exp_a.size() !== 0) $display("FAIL bp_leftover: got %0d pending want 0", exp_a.size());
        else passed++;
    endtask

    task automatic test_random_stream();
        int   sent = 0;
        int   got  = 0;
        res_t o;
        res_t e;
        for (int cyc = 0; cyc < 400 && got < 30; cyc++) begin
            @(negedge clk);
            bus_a.ready_i = ($urandom_range(0, 9) < 6);
            bus_a.valid_i = (sent < 30) && ($urandom_range(0, 9) < 7);
            bus_a.operand_a_i = $urandom;
            bus_a.operand_b_i = $urandom;
            bus_a.sub_i       = 1'($urandom_range(0, 1));
            bus_a.carry_i     = 1'($urandom_range(0, 1));
            #1;
            if (bus_a.ready_i) begin
                checks++;
                if (bus_a.ready_o !== 1'b1) $display("FAIL stream_ready cyc%0d: got %b want 1", cyc, bus_a.ready_o);
                else passed++;
            end
            if (bus_a.valid_o === 1'b1 && bus_a.ready_i) begin
                o.sum   = bus_a.sum_o;
                o.carry = bus_a.carry_o;
                o.ovf   = bus_a.overflow_o;
                checks++;
                if (exp_a.size() == 0) begin
                    $display("FAIL stream_unexpected cyc%0d: got %h want nothing", cyc, o);
                end else begin
                    e = exp_a.pop_front();
                    if (o !== e) $display("FAIL stream_result[%0d]: got %h want %h", got, o, e);
                    else passed++;
                end
                got++;
            end
            if (bus_a.valid_i && bus_a.ready_o) begin
                exp_a.push_back(model(W, bus_a.operand_a_i, bus_a.operand_b_i, bus_a.sub_i, bus_a.carry_i));
                sent++;
            end
        end
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        bus_a.ready_i = 1'b1;
        checks++;
        if (got !== 30) $display("FAIL stream_count: got %0d results want 30", got);
        else passed++;
        $display("stream: %0d transactions drained", got);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        bus_a.ready_i     = 1'b0;
        bus_a.valid_i     = 1'b1;
        bus_a.operand_a_i = 32'h7FFF_FFFF;
        bus_a.operand_b_i = 32'h0000_0001;
        bus_a.sub_i       = 1'b0;
        bus_a.carry_i     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_a.operand_a_i = 32'h1234_5678;
        bus_a.operand_b_i = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        bus_a.valid_i = 1'b0;
        #1;
        checks++;
        if ({bus_a.valid_o, bus_a.sum_o, bus_a.overflow_o} !== {1'b1, 32'h8000_0000, 1'b1})
            $display("FAIL midflight_pre: valid=%b sum=%h v=%b want 1 80000000 1",
                     bus_a.valid_o, bus_a.sum_o, bus_a.overflow_o);
        else passed++;
        rst_a = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({bus_a.valid_o, bus_a.sum_o, bus_a.carry_o, bus_a.overflow_o} !== 35'd0)
            $display("FAIL midflight_reset: valid=%b sum=%h c=%b v=%b want all 0",
                     bus_a.valid_o, bus_a.sum_o, bus_a.carry_o, bus_a.overflow_o);
        else passed++;
        checks++;
        if (bus_a.ready_o !== 1'b1) $display("FAIL midflight_ready: got %b want 1", bus_a.ready_o);
        else passed++;
        rst_a = 1'b0;
        bus_a.ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk); #1;
            checks++;
            if (bus_a.valid_o !== 1'b0) $display("FAIL midflight_stale[%0d]: got %b want 0", i, bus_a.valid_o);
            else passed++;
        end
        $display("midflight: reset discarded in-flight items");
    endtask

    task automatic test_narrow();
        int   got = 0;
        res_t o;
        res_t e;
        @(negedge clk);
        bus_b.ready_i     = 1'b1;
        bus_b.valid_i     = 1'b1;
        bus_b.operand_a_i = 8'h7F;
        bus_b.operand_b_i = 8'h01;
        bus_b.sub_i       = 1'b0;
        bus_b.carry_i     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_b.valid_i = 1'b0;
        #1;
        checks++;
        if ({bus_b.valid_o, bus_b.sum_o, bus_b.carry_o, bus_b.overflow_o} !== {1'b1, 8'h80, 1'b0, 1'b1})
            $display("FAIL narrow_single: valid=%b sum=%h c=%b v=%b want 1 80 0 1",
                     bus_b.valid_o, bus_b.sum_o, bus_b.carry_o, bus_b.overflow_o);
        else passed++;
        $display("narrow: 7f+01 -> sum=%h c=%b v=%b", bus_b.sum_o, bus_b.carry_o, bus_b.overflow_o);
        for (int cyc = 0; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus_b.valid_i     = (cyc < 20);
            bus_b.operand_a_i = 8'($urandom_range(0, 255));
            bus_b.operand_b_i = 8'($urandom_range(0, 255));
            bus_b.sub_i       = 1'($urandom_range(0, 1));
            bus_b.carry_i     = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (bus_b.ready_o !== 1'b1) $display("FAIL narrow_ready cyc%0d: got %b want 1", cyc, bus_b.ready_o);
            else passed++;
            if (cyc >= 1) begin
                checks++;
                if (bus_b.valid_o !== 1'b1) $display("FAIL narrow_rate cyc%0d: got %b want 1", cyc, bus_b.valid_o);
                else passed++;
            end
            if (bus_b.valid_o === 1'b1) begin
                o.sum   = {24'd0, bus_b.sum_o};
                o.carry = bus_b.carry_o;
                o.ovf   = bus_b.overflow_o;
                checks++;
                if (exp_b.size() == 0) begin
                    $display("FAIL narrow_unexpected cyc%0d: got %h want nothing", cyc, o);
                end else begin
                    e = exp_b.pop_front();
                    if (o !== e) $display("FAIL narrow_result[%0d]: got %h want %h", got, o, e);
                    else passed++;
                end
                got++;
            end
            if (bus_b.valid_i && bus_b.ready_o)
                exp_b.push_back(model(WN, {24'd0, bus_b.operand_a_i}, {24'd0, bus_b.operand_b_i},
                                      bus_b.sub_i, bus_b.carry_i));
        end
        @(negedge clk);
        bus_b.valid_i = 1'b0;
        checks++;
        if (got !== 20) $display("FAIL narrow_count: got %0d results want 20", got);
        else passed++;
        $display("narrow stream: %0d transactions", got);
    endtask

    initial begin
        bus_a.valid_i = 1'b0; bus_a.operand_a_i = '0; bus_a.operand_b_i = '0;
        bus_a.sub_i = 1'b0; bus_a.carry_i = 1'b0; bus_a.ready_i = 1'b1;
        bus_b.valid_i = 1'b0; bus_b.operand_a_i = '0; bus_b.operand_b_i = '0;
        bus_b.sub_i = 1'b0; bus_b.carry_i = 1'b0; bus_b.ready_i = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_arith();
        test_backpressure();
        test_random_stream();
        test_reset_midflight();
        test_narrow();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
